// File: rtl/arb_pkg.sv
// Shared types and elaboration helpers for the weighted round-robin arbiter.
package arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } arb_state_e;

    localparam int unsigned MAX_REQ = 32;

    // Index width that never collapses to zero bits.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Largest of the first n entries of a weight table.
    function automatic int unsigned max_weight(input int unsigned w [MAX_REQ], input int unsigned n);
        int unsigned m;
        m = 0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (i < n && w[i] > m) m = w[i];
        end
        return m;
    endfunction

endpackage

// File: rtl/weighted_rr_param_arbiter_if.sv
// Requester-side and output-side signals of the weighted round-robin arbiter.
interface weighted_rr_param_arbiter_if
    import arb_pkg::*;
#(
    parameter int  N_REQ  = 4,
    parameter type T_DATA = logic [31:0]
);
    localparam int ID_W = clog2_min1(N_REQ);

    // A beat moves on any cycle where valid and ready are both high on the same
    // channel; valid never waits for ready, ready may depend combinationally on valid.
    logic [N_REQ-1:0] req_valid;
    T_DATA            req_data [N_REQ];
    logic [N_REQ-1:0] req_ready;
    logic             out_valid;
    T_DATA            out_data;
    logic [ID_W-1:0]  out_id;
    logic             out_ready;
    logic             busy;

    modport master (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_data, out_id, busy
    );

    modport slave (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_data, out_id, busy
    );

endinterface

// File: rtl/rr_priority_pick.sv
// Rotating-priority picker: first set request at or after ptr, wrapping to 0.
module rr_priority_pick #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  idx,
    output logic             any
);

    logic [ID_W-1:0] j;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            j = ID_W'((int'(ptr) + k) % N_REQ);
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = j;
            end
        end
    end

endmodule

// File: rtl/weighted_rr_param_arbiter.sv
// Weighted round-robin arbiter: a winner keeps the channel for up to WEIGHT[i]
// consecutive beats, then priority rotates; output goes through one register stage.
module weighted_rr_param_arbiter
    import arb_pkg::*;
#(
    parameter int          N_REQ          = 4,
    parameter type         T_DATA         = logic [31:0],
    parameter int unsigned WEIGHT [N_REQ] = '{default: 1}
) (
    input  logic                        clk,
    input  logic                        rst_n,
    weighted_rr_param_arbiter_if.slave  bus,
    output arb_state_e                  dbg_state
);

    function automatic int unsigned weight_max();
        int unsigned m;
        m = 0;
        for (int i = 0; i < N_REQ; i++) begin
            if (WEIGHT[i] > m) m = WEIGHT[i];
        end
        return m;
    endfunction

    localparam int ID_W   = clog2_min1(N_REQ);
    localparam int CRED_W = clog2_min1(weight_max() + 1);

    if (N_REQ < 2) begin : g_bad_n
        $error("weighted_rr_param_arbiter: N_REQ must be >= 2");
    end

    logic              w_one [N_REQ];
    logic [CRED_W-1:0] w_m1  [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_w
        if (WEIGHT[g] == 0) begin : g_bad_w
            $error("weighted_rr_param_arbiter: WEIGHT entries must be non-zero");
        end
        assign w_one[g] = (WEIGHT[g] == 1);
        assign w_m1[g]  = CRED_W'(WEIGHT[g] - 1);
    end

    arb_state_e        state, state_n;
    logic [ID_W-1:0]   owner, owner_n, ptr, ptr_n;
    logic [CRED_W-1:0] credit, credit_n;
    logic              out_valid_q;
    T_DATA             out_data_q;
    logic [ID_W-1:0]   out_id_q;

    logic              load_en, keep, xfer;
    logic [N_REQ-1:0]  gnt, pick_gnt;
    logic [ID_W-1:0]   gnt_idx, pick_idx, pick_ptr;
    logic              pick_any;

    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] i);
        return (i == ID_W'(N_REQ - 1)) ? '0 : ID_W'(i + 1'b1);
    endfunction

    // A released owner hands priority to its neighbour within the same cycle.
    assign pick_ptr = (state == SERVE) ? next_id(owner) : ptr;

    rr_priority_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
        .req (bus.req_valid),
        .ptr (pick_ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        load_en  = !out_valid_q || bus.out_ready;
        keep     = (state == SERVE) && bus.req_valid[owner];
        gnt      = '0;
        gnt_idx  = pick_idx;
        xfer     = 1'b0;
        state_n  = state;
        owner_n  = owner;
        ptr_n    = ptr;
        credit_n = credit;
        if (load_en) begin
            if (keep) begin
                gnt[owner] = 1'b1;
                gnt_idx    = owner;
                xfer       = 1'b1;
                if (credit > CRED_W'(1)) begin
                    credit_n = credit - 1'b1;
                end else begin
                    state_n  = IDLE;
                    ptr_n    = next_id(owner);
                    credit_n = '0;
                end
            end else begin
                // Owner went quiet: drop its leftover credit before re-arbitrating.
                if (state == SERVE) begin
                    state_n  = IDLE;
                    ptr_n    = next_id(owner);
                    credit_n = '0;
                end
                if (pick_any) begin
                    gnt  = pick_gnt;
                    xfer = 1'b1;
                    if (w_one[pick_idx]) begin
                        ptr_n = next_id(pick_idx);
                    end else begin
                        state_n  = SERVE;
                        owner_n  = pick_idx;
                        credit_n = w_m1[pick_idx];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            owner       <= '0;
            ptr         <= '0;
            credit      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
        end else begin
            state  <= state_n;
            owner  <= owner_n;
            ptr    <= ptr_n;
            credit <= credit_n;
            if (xfer) begin
                out_valid_q <= 1'b1;
                out_data_q  <= bus.req_data[gnt_idx];
                out_id_q    <= gnt_idx;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.req_ready = rst_n ? gnt : '0;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_id    = out_id_q;
    assign bus.busy      = (state == SERVE);
    assign dbg_state     = state;

endmodule

// File: tb/tb_weighted_rr_param_arbiter.sv
// Directed bench for weighted_rr_param_arbiter: three instances with different weight tables.
module tb_weighted_rr_param_arbiter;
    import arb_pkg::*;

    localparam int          N     = 4;
    localparam logic [31:0] DBASE = 32'hD000_0000;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         out_ready = 1'b1;
    logic [N-1:0] req_valid = '0;
    logic [31:0]  req_data [N];

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] exp_q [$];
    logic [3:0]  vld_q [$];
    logic        bsy_q [$];

    always #5 clk = ~clk;

    // Instance 0: equal weights, 1: '{3,1,2,1}, 2: '{4,1,2,1}.
    weighted_rr_param_arbiter_if #(.N_REQ(N)) bus_eq ();
    weighted_rr_param_arbiter_if #(.N_REQ(N)) bus_w ();
    weighted_rr_param_arbiter_if #(.N_REQ(N)) bus_f ();

    arb_state_e st [3];

    weighted_rr_param_arbiter #(.N_REQ(N)) u_eq (
        .clk(clk), .rst_n(rst_n), .bus(bus_eq.slave), .dbg_state(st[0]));
    weighted_rr_param_arbiter #(.N_REQ(N), .WEIGHT('{3, 1, 2, 1})) u_w (
        .clk(clk), .rst_n(rst_n), .bus(bus_w.slave), .dbg_state(st[1]));
    weighted_rr_param_arbiter #(.N_REQ(N), .WEIGHT('{4, 1, 2, 1})) u_f (
        .clk(clk), .rst_n(rst_n), .bus(bus_f.slave), .dbg_state(st[2]));

    assign bus_eq.req_valid = req_valid;
    assign bus_w.req_valid  = req_valid;
    assign bus_f.req_valid  = req_valid;
    assign bus_eq.req_data  = req_data;
    assign bus_w.req_data   = req_data;
    assign bus_f.req_data   = req_data;
    assign bus_eq.out_ready = out_ready;
    assign bus_w.out_ready  = out_ready;
    assign bus_f.out_ready  = out_ready;

    logic [N-1:0] obs_ready [3];
    logic [1:0]   obs_id    [3];
    logic [31:0]  obs_data  [3];
    logic         obs_valid [3];
    logic         obs_busy  [3];

    assign obs_ready[0] = bus_eq.req_ready;
    assign obs_ready[1] = bus_w.req_ready;
    assign obs_ready[2] = bus_f.req_ready;
    assign obs_id[0]    = bus_eq.out_id;
    assign obs_id[1]    = bus_w.out_id;
    assign obs_id[2]    = bus_f.out_id;
    assign obs_data[0]  = bus_eq.out_data;
    assign obs_data[1]  = bus_w.out_data;
    assign obs_data[2]  = bus_f.out_data;
    assign obs_valid[0] = bus_eq.out_valid;
    assign obs_valid[1] = bus_w.out_valid;
    assign obs_valid[2] = bus_f.out_valid;
    assign obs_busy[0]  = bus_eq.busy;
    assign obs_busy[1]  = bus_w.busy;
    assign obs_busy[2]  = bus_f.busy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reset with all requesters asserting so that req_ready gating is visible.
    task automatic do_reset();
        rst_n     = 1'b0;
        out_ready = 1'b1;
        req_valid = '1;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("rst_out_valid", obs_valid[d], 0);
            chk("rst_out_id", obs_id[d], 0);
            chk("rst_out_data", obs_data[d], 0);
            chk("rst_busy", obs_busy[d], 0);
            chk("rst_req_ready", obs_ready[d], 0);
            chk("rst_state", st[d] == SERVE, 0);
        end
        #2 rst_n = 1'b1;
        #1;
    endtask

    // Per cycle: apply next valid vector, check the grant, then the registered beat.
    task automatic run_seq(input int d, input int n);
        logic [31:0] e;
        logic        b;
        for (int c = 0; c < n; c++) begin
            if (exp_q.size() == 0) begin
                chk("exp_q_underflow", 1, 0);
                return;
            end
            if (vld_q.size() != 0) req_valid = vld_q.pop_front();
            e = exp_q.pop_front();
            #1;
            chk("req_ready", obs_ready[d], 32'(1) << e);
            if (bsy_q.size() != 0) begin
                b = bsy_q.pop_front();
                chk("busy", obs_busy[d], b);
                chk("state", st[d] == SERVE, b);
            end
            @(posedge clk);
            #1;
            chk("out_id", obs_id[d], e);
            chk("out_data", obs_data[d], DBASE | e);
            chk("out_valid", obs_valid[d], 1);
        end
    endtask

    initial begin
        int ids2 [10];
        int bsy2 [10];
        int ids3 [10];
        int vld3 [10];
        ids2 = '{0, 0, 0, 1, 2, 2, 3, 0, 0, 0};
        bsy2 = '{0, 1, 1, 0, 0, 1, 0, 0, 1, 1};
        ids3 = '{0, 0, 1, 2, 2, 0, 0, 0, 0, 1};
        vld3 = '{7, 7, 6, 6, 7, 7, 7, 7, 7, 7};
        for (int i = 0; i < N; i++) req_data[i] = DBASE | i;

        // Equal weights, everyone valid: plain rotation.
        do_reset();
        req_valid = '1;
        for (int c = 0; c < 10; c++) exp_q.push_back(c % 4);
        run_seq(0, 10);

        // Weighted rotation with busy tracking.
        do_reset();
        req_valid = '1;
        for (int c = 0; c < 10; c++) begin
            exp_q.push_back(ids2[c]);
            bsy_q.push_back(bsy2[c] != 0);
        end
        run_seq(1, 10);

        // Owner 0 (weight 4) drops early; credit is forfeited, next grant is full again.
        do_reset();
        for (int c = 0; c < 10; c++) begin
            exp_q.push_back(ids3[c]);
            vld_q.push_back(4'(vld3[c]));
        end
        run_seq(2, 10);

        // Downstream stall while owner 0 holds one remaining credit.
        do_reset();
        req_valid = '1;
        exp_q.push_back(0);
        exp_q.push_back(0);
        run_seq(1, 2);
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("stall_req_ready", obs_ready[1], 0);
            chk("stall_busy", obs_busy[1], 1);
            @(posedge clk);
            #1;
            chk("stall_out_id", obs_id[1], 0);
            chk("stall_out_data", obs_data[1], DBASE);
            chk("stall_out_valid", obs_valid[1], 1);
        end
        out_ready = 1'b1;
        foreach (ids2[c]) if (c >= 2 && c < 7) exp_q.push_back(ids2[c]);
        run_seq(1, 5);

        // Pointer wrap 3 -> 0, idle drain, then pointer continues from 1.
        do_reset();
        vld_q.push_back(4'h8);
        vld_q.push_back(4'h9);
        exp_q.push_back(3);
        exp_q.push_back(0);
        run_seq(0, 2);
        req_valid = '0;
        #1;
        chk("idle_req_ready", obs_ready[0], 0);
        @(posedge clk);
        #1;
        chk("drain_out_valid", obs_valid[0], 0);
        vld_q.push_back(4'h9);
        exp_q.push_back(3);
        run_seq(0, 1);

        // Asynchronous reset in the middle of a weight-3 burst.
        do_reset();
        req_valid = '1;
        exp_q.push_back(0);
        run_seq(1, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_out_valid", obs_valid[1], 0);
        chk("mid_out_id", obs_id[1], 0);
        chk("mid_out_data", obs_data[1], 0);
        chk("mid_busy", obs_busy[1], 0);
        chk("mid_req_ready", obs_ready[1], 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        for (int c = 0; c < 4; c++) begin
            exp_q.push_back(ids2[c]);
            bsy_q.push_back(bsy2[c] != 0);
        end
        run_seq(1, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        n_err++;
        $display("FAIL watchdog: got timeout expected completion at %0t", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
